// File: rtl/opt_stim_sig.sv
// opt_stim_sig: toggle-channel stimulus generator with MISR response compactor.
// Drives NCH free-running toggle channels (programmable half-periods) into a
// combinational DUT for run_len cycles and folds the DUT response into a MISR,
// so two netlists of the same DUT can be compared by final signature alone.
//
// Ports:
//   clk          - single clock, rising-edge
//   sync_reset_n - synchronous active-low reset
//   start        - begin a run (honoured in IDLE/DONE only)
//   half_period  - channel i half-period at [i*PW +: PW]; 0 disables channel
//   run_len      - number of RUN cycles
//   resp         - DUT response, sampled every RUN cycle
//   stim         - registered stimulus to the DUT
//   busy         - high while running
//   done         - high once a run has completed
//   signature    - registered MISR contents
module opt_stim_sig #(
    parameter int unsigned     NCH   = 3,
    parameter int unsigned     PW    = 8,
    parameter int unsigned     RUNW  = 16,
    parameter int unsigned     RESPW = 1,
    parameter int unsigned     SIGW  = 16,
    parameter logic [SIGW-1:0] POLY  = SIGW'(16'h1021)
) (
    input  logic              clk,
    input  logic              sync_reset_n,
    input  logic              start,
    input  logic [NCH*PW-1:0] half_period,
    input  logic [RUNW-1:0]   run_len,
    input  logic [RESPW-1:0]  resp,
    output logic [NCH-1:0]    stim,
    output logic              busy,
    output logic              done,
    output logic [SIGW-1:0]   signature
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]             state_q,  state_d;
    logic [NCH-1:0][PW-1:0] half_q,   half_d;
    logic [NCH-1:0][PW-1:0] cnt_q,    cnt_d;
    logic [RUNW-1:0]        len_q,    len_d;
    logic [RUNW-1:0]        cyc_q,    cyc_d;
    logic [NCH-1:0]         stim_d;
    logic                   busy_d;
    logic                   done_d;
    logic [SIGW-1:0]        sig_d;

    logic [NCH-1:0][PW-1:0] cnt_step_c;
    logic [NCH-1:0]         stim_step_c;
    logic [SIGW-1:0]        sig_step_c;
    logic                   last_cyc_c;

    // Per-channel half-period counters; a disabled channel parks at 0.
    always_comb begin
        cnt_step_c  = cnt_q;
        stim_step_c = stim;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (half_q[i] == '0) begin
                cnt_step_c[i]  = '0;
                stim_step_c[i] = 1'b0;
            end else if (cnt_q[i] == half_q[i] - PW'(1)) begin
                cnt_step_c[i]  = '0;
                stim_step_c[i] = ~stim[i];
            end else begin
                cnt_step_c[i]  = cnt_q[i] + PW'(1);
                stim_step_c[i] = stim[i];
            end
        end
    end

    // One MISR step: shift left, feed back POLY on MSB, fold in the response.
    always_comb begin
        sig_step_c = {signature[SIGW-2:0], 1'b0}
                   ^ (signature[SIGW-1] ? POLY : '0)
                   ^ SIGW'(resp);
    end

    // Last RUN cycle: the cycle counter reaches the latched length minus one.
    always_comb begin
        last_cyc_c = (cyc_q == len_q - RUNW'(1));
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        half_d  = half_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        cyc_d   = cyc_q;
        stim_d  = stim;
        busy_d  = busy;
        done_d  = done;
        sig_d   = signature;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    half_d = half_period;
                    len_d  = run_len;
                    cnt_d  = '0;
                    cyc_d  = '0;
                    stim_d = '0;
                    sig_d  = '0;
                    if (run_len == '0) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                    end
                end
            end

            S_RUN: begin
                cnt_d  = cnt_step_c;
                stim_d = stim_step_c;
                sig_d  = sig_step_c;
                cyc_d  = cyc_q + RUNW'(1);
                if (last_cyc_c) begin
                    // Final MISR update has been taken above; park the channels.
                    state_d = S_DONE;
                    stim_d  = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                stim_d  = '0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!sync_reset_n) begin
            state_q   <= S_IDLE;
            half_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            cyc_q     <= '0;
            stim      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            signature <= '0;
        end else begin
            state_q   <= state_d;
            half_q    <= half_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            cyc_q     <= cyc_d;
            stim      <= stim_d;
            busy      <= busy_d;
            done      <= done_d;
            signature <= sig_d;
        end
    end

endmodule

// File: tb/tb_opt_stim_sig.sv
// Bench for opt_stim_sig: per-scenario tasks with a queue-based scoreboard of
// per-cycle stimulus and final signatures computed from a behavioural model.
module tb_opt_stim_sig;

    localparam int unsigned NCH   = 3;
    localparam int unsigned PW    = 8;
    localparam int unsigned RUNW  = 16;
    localparam int unsigned RESPW = 1;
    localparam int unsigned SIGW  = 16;
    localparam int unsigned HPW   = NCH * PW;

    logic              clk = 1'b0;
    logic              sync_reset_n;
    logic              start;
    logic [HPW-1:0]    half_period;
    logic [RUNW-1:0]   run_len;
    logic [RESPW-1:0]  resp;
    logic [NCH-1:0]    stim;
    logic              busy;
    logic              done;
    logic [SIGW-1:0]   signature;

    int resp_mode;  // 0: resp=0, 1: resp=1, 2: resp = xor of stim (combinational DUT)
    int n_checks;
    int n_fail;

    logic [NCH-1:0]  stim_q[$];
    logic [SIGW-1:0] sig_q[$];

    opt_stim_sig dut (
        .clk          (clk),
        .sync_reset_n (sync_reset_n),
        .start        (start),
        .half_period  (half_period),
        .run_len      (run_len),
        .resp         (resp),
        .stim         (stim),
        .busy         (busy),
        .done         (done),
        .signature    (signature)
    );

    always #5 clk = ~clk;

    assign resp = (resp_mode == 2) ? ^stim : 1'(resp_mode == 1);

    function automatic logic [SIGW-1:0] misr_step(input logic [SIGW-1:0] s, input logic r);
        return {s[SIGW-2:0], 1'b0} ^ (s[SIGW-1] ? 16'h1021 : 16'h0000) ^ {15'b0, r};
    endfunction

    // Push expected per-cycle stim and final signature, run, compare as outputs appear.
    task automatic run_check(input logic [HPW-1:0] hp, input logic [RUNW-1:0] len,
                             input int mode, input int pulse_at, input string name);
        logic [NCH-1:0]  es;
        logic [NCH-1:0]  ex;
        logic [PW-1:0]   h;
        logic [SIGW-1:0] s;
        logic [SIGW-1:0] exs;
        int n;
        s = '0;
        for (int c = 0; c < int'(len); c++) begin
            for (int i = 0; i < int'(NCH); i++) begin
                h = hp[i*PW +: PW];
                if (h == '0) es[i] = 1'b0;
                else         es[i] = 1'(((c / int'(h)) % 2));
            end
            stim_q.push_back(es);
            s = misr_step(s, (mode == 2) ? ^es : (mode == 1));
        end
        sig_q.push_back(s);

        resp_mode   = mode;
        half_period = hp;
        run_len     = len;
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;

        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s start: busy=%b done=%b required busy=1 done=0", name, busy, done);
        end
        n_checks++;
        if (signature !== 16'h0000) begin
            n_fail++;
            $display("FAIL %s seed: signature=%h required 0000", name, signature);
        end

        n = 0;
        while (busy === 1'b1 && n < int'(len) + 4) begin
            ex = (stim_q.size() > 0) ? stim_q.pop_front() : '0;
            n_checks++;
            if (stim !== ex) begin
                n_fail++;
                $display("FAIL %s stim cycle %0d: got %b required %b", name, n, stim, ex);
            end
            if (n == pulse_at) begin
                start       = 1'b1;
                run_len     = 16'd3;
                half_period = HPW'($urandom);
            end
            @(posedge clk); #1;
            if (n == pulse_at) start = 1'b0;
            n++;
        end
        stim_q.delete();

        n_checks++;
        if (n != int'(len)) begin
            n_fail++;
            $display("FAIL %s busy length: got %0d required %0d", name, n, len);
        end
        exs = sig_q.pop_front();
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || stim !== '0 || signature !== exs) begin
            n_fail++;
            $display("FAIL %s end: done=%b busy=%b stim=%b sig=%h required 1 0 000 %h",
                     name, done, busy, stim, signature, exs);
        end
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b1 || stim !== '0 || signature !== exs) begin
            n_fail++;
            $display("FAIL %s hold: done=%b stim=%b sig=%h required 1 000 %h",
                     name, done, stim, signature, exs);
        end
    endtask

    task automatic test_reset;
        sync_reset_n = 1'b0;
        start        = 1'b1;
        half_period  = {8'd7, 8'd5, 8'd1};
        run_len      = 16'd30;
        resp_mode    = 1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (stim !== '0 || busy !== 1'b0 || done !== 1'b0 || signature !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset: stim=%b busy=%b done=%b sig=%h required all zero",
                     stim, busy, done, signature);
        end
        start        = 1'b0;
        sync_reset_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset idle: busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_waveform;
        run_check({8'd7, 8'd5, 8'd1}, 16'd30, 0, -1, "waveform_resp0");
        n_checks++;
        if (signature !== 16'h0000) begin
            n_fail++;
            $display("FAIL waveform sig: got %h required 0000", signature);
        end
        run_check({8'd7, 8'd5, 8'd1}, 16'd30, 2, -1, "waveform_xor");
    endtask

    task automatic test_misr;
        run_check({8'd2, 8'd3, 8'd1}, 16'd1, 1, -1, "misr_len1");
        n_checks++;
        if (signature !== 16'h0001) begin
            n_fail++;
            $display("FAIL misr len1: got %h required 0001", signature);
        end
        run_check({8'd2, 8'd3, 8'd1}, 16'd2, 1, -1, "misr_len2");
        n_checks++;
        if (signature !== 16'h0003) begin
            n_fail++;
            $display("FAIL misr len2: got %h required 0003", signature);
        end
        run_check({8'd2, 8'd3, 8'd1}, 16'd17, 1, -1, "misr_len17");
        n_checks++;
        if (signature !== 16'hEFDE) begin
            n_fail++;
            $display("FAIL misr len17: got %h required efde", signature);
        end
    endtask

    // Entered from DONE with a nonzero signature, so the reseed is observable.
    task automatic test_run_len_zero;
        half_period = {8'd1, 8'd1, 8'd1};
        run_len     = 16'd0;
        resp_mode   = 1;
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || signature !== 16'h0000 || stim !== '0) begin
            n_fail++;
            $display("FAIL len0: done=%b busy=%b sig=%h stim=%b required 1 0 0000 000",
                     done, busy, signature, stim);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (stim !== '0 || busy !== 1'b0 || signature !== 16'h0000) begin
                n_fail++;
                $display("FAIL len0 hold %0d: stim=%b busy=%b sig=%h", i, stim, busy, signature);
            end
        end
    endtask

    task automatic test_disabled_channel;
        run_check({8'd3, 8'd0, 8'd2}, 16'd20, 2, -1, "disabled_ch1");
        run_check({8'd255, 8'd0, 8'd4}, 16'd24, 2, -1, "max_half_period");
    endtask

    task automatic test_start_ignored;
        run_check({8'd7, 8'd5, 8'd1}, 16'd30, 2, 5, "start_ignored");
    endtask

    task automatic test_mid_run_reset;
        resp_mode   = 2;
        half_period = {8'd7, 8'd5, 8'd1};
        run_len     = 16'd30;
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        sync_reset_n = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (stim !== '0 || busy !== 1'b0 || done !== 1'b0 || signature !== 16'h0000) begin
            n_fail++;
            $display("FAIL mid-run reset: stim=%b busy=%b done=%b sig=%h required all zero",
                     stim, busy, done, signature);
        end
        sync_reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || stim !== '0) begin
            n_fail++;
            $display("FAIL post-reset idle: busy=%b done=%b stim=%b", busy, done, stim);
        end
    endtask

    task automatic test_restart;
        run_check({8'd2, 8'd1, 8'd3}, 16'd6, 2, -1, "pre_restart");
        run_check({8'd1, 8'd2, 8'd3}, 16'd4, 1, -1, "restart_len4");
        n_checks++;
        if (signature !== 16'h000F) begin
            n_fail++;
            $display("FAIL restart sig: got %h required 000f", signature);
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        start       = 1'b0;
        resp_mode   = 0;
        half_period = '0;
        run_len     = '0;
        test_reset();
        test_waveform();
        test_misr();
        test_run_len_zero();
        test_disabled_channel();
        test_start_ignored();
        test_mid_run_reset();
        test_restart();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
